// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states, flag indices and default width for the ALU execute stage
package alu_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_MVN   = 3'b011;
  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [2:0] OP_PASSB = 3'b101;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_HOLD = 2'd2;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;

endpackage

// File: rtl/alu_seq_multiplier.sv
// rtl/alu_seq_multiplier.sv - shift-add multiplier, one multiplier bit per cycle LSB first
// o_done is high during the final iteration; o_product already includes that iteration.
module alu_seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_run;
  logic [2*WIDTH-1:0] w_partial;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_partial  = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next = r_acc + w_partial;
  assign o_done     = r_run && (r_cnt == CW'(WIDTH - 1));
  assign o_product  = w_acc_next;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_acc    <= '0;
      r_mplier <= i_b;
      r_cnt    <= '0;
      r_run    <= 1'b1;
    end else if (r_run) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (o_done) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_execute_stage.sv
// rtl/alu_execute_stage.sv - ALU execute stage with registered result/flags and valid/ready handshakes
// Define ALU_MUL_EN to build the multi-cycle MUL (opcode 100); otherwise it behaves as reserved.
module alu_execute_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic [2:0]       alu_op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] pipeline_out,
  output logic [2:0]       status,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  state_t           r_state;
  logic [WIDTH-1:0] r_result;
  logic [2:0]       r_status;
  logic             r_out_valid;

  logic             w_accept;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_result;
  logic             w_v;
  logic [2:0]       w_flags;

  assign in_ready     = (r_state == ST_IDLE) | ((r_state == ST_HOLD) & out_ready);
  assign w_accept     = in_valid & in_ready;
  assign pipeline_out = r_result;
  assign status       = r_status;
  assign out_valid    = r_out_valid;

  assign w_sum  = Ain + Bin;
  assign w_diff = Ain - Bin;

  always_comb begin
    w_result = '0;
    w_v      = 1'b0;
    case (alu_op)
      OP_ADD: begin
        w_result = w_sum;
        w_v      = (Ain[WIDTH-1] == Bin[WIDTH-1]) && (w_sum[WIDTH-1] != Ain[WIDTH-1]);
      end
      OP_SUB: begin
        w_result = w_diff;
        w_v      = (Ain[WIDTH-1] != Bin[WIDTH-1]) && (w_diff[WIDTH-1] != Ain[WIDTH-1]);
      end
      OP_AND:   w_result = Ain & Bin;
      OP_MVN:   w_result = ~Bin;
      OP_PASSB: w_result = Bin;
      default:  w_result = '0;
    endcase
  end

  always_comb begin
    w_flags         = 3'b000;
    w_flags[FLAG_Z] = (w_result == '0);
    w_flags[FLAG_N] = w_result[WIDTH-1];
    w_flags[FLAG_V] = w_v;
  end

`ifdef ALU_MUL_EN
  logic               w_is_mul;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_product;
  logic [2:0]         w_mul_flags;

  assign w_is_mul = (alu_op == OP_MUL);
  assign busy     = (r_state == ST_BUSY);

  alu_seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .i_rst     (reset),
    .i_start   (w_accept & w_is_mul),
    .i_a       (Ain),
    .i_b       (Bin),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  always_comb begin
    w_mul_flags         = 3'b000;
    w_mul_flags[FLAG_Z] = (w_product[WIDTH-1:0] == '0);
    w_mul_flags[FLAG_N] = w_product[WIDTH-1];
    w_mul_flags[FLAG_V] = |w_product[2*WIDTH-1:WIDTH];
  end
`else
  assign busy = 1'b0;
`endif

  // pipeline_out is only written on completion: it feeds the A-side mux even when idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_result    <= '0;
      r_status    <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
`ifdef ALU_MUL_EN
      if (w_is_mul) begin
        r_state     <= ST_BUSY;
        r_out_valid <= 1'b0;
      end else
`endif
      begin
        r_result    <= w_result;
        r_status    <= w_flags;
        r_out_valid <= 1'b1;
        r_state     <= ST_HOLD;
      end
    end
`ifdef ALU_MUL_EN
    else if ((r_state == ST_BUSY) && w_mul_done) begin
      r_result    <= w_product[WIDTH-1:0];
      r_status    <= w_mul_flags;
      r_out_valid <= 1'b1;
      r_state     <= ST_HOLD;
    end
`endif
    else if ((r_state == ST_HOLD) && out_ready) begin
      r_out_valid <= 1'b0;
      r_state     <= ST_IDLE;
    end
  end

endmodule
